// File: rtl/key_lut_mux_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_lut_mux_core                                             |
// | Description : Combinational key-matching lookup. Every entry whose key     |
// |               equals the input key contributes its data to a bitwise OR.   |
// |               If no entry matches, the default value is driven instead.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_lut_mux_core #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                 key,
  input  logic [DATA_LEN-1:0]                default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                out,
  output logic                               hit,
  output logic                               multi_hit
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  w_keys  [NR_KEY];
  logic [DATA_LEN-1:0] w_datas [NR_KEY];
  logic [NR_KEY-1:0]   w_match;
  logic [DATA_LEN-1:0] w_or;
  logic                w_any;
  logic                w_multi;

  // Entry 0 occupies the MSBs of the table; the key is the upper part of each entry.
  for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
    assign w_keys[gi]  = lut[(NR_KEY-gi)*PAIR_LEN-1 -: KEY_LEN];
    assign w_datas[gi] = lut[(NR_KEY-gi)*PAIR_LEN-1-KEY_LEN -: DATA_LEN];
    assign w_match[gi] = (key == w_keys[gi]);
  end

  // OR together the data of all matching entries; a second match sets the multi flag.
  always_comb begin
    w_or    = '0;
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (w_match[i]) begin
        w_multi = w_multi | w_any;
        w_any   = 1'b1;
        w_or    = w_or | w_datas[i];
      end
    end
  end

  assign out       = w_any ? w_or : default_out;
  assign hit       = w_any;
  assign multi_hit = w_multi;

endmodule
`default_nettype wire

// File: rtl/key_lut_mux_dflt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_lut_mux_dflt                                             |
// | Description : Key lookup multiplexer with default value, plus a registered |
// |               copy of the result and hit flag for pipelined consumers.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_lut_mux_dflt #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit,
  output logic                                 multi_hit,
  output logic [DATA_LEN-1:0]                  out_q,
  output logic                                 hit_q
);

  logic [DATA_LEN-1:0] w_out;
  logic                w_hit;
  logic [DATA_LEN-1:0] r_out_q;
  logic                r_hit_q;

  key_lut_mux_core #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_core (
    .key         (key),
    .default_out (default_out),
    .lut         (lut),
    .out         (w_out),
    .hit         (w_hit),
    .multi_hit   (multi_hit)
  );

  // Capture the combinational result every cycle; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q <= '0;
      r_hit_q <= 1'b0;
    end else begin
      r_out_q <= w_out;
      r_hit_q <= w_hit;
    end
  end

  assign out   = w_out;
  assign hit   = w_hit;
  assign out_q = r_out_q;
  assign hit_q = r_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_key_lut_mux_dflt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_lut_mux_dflt                                          |
// | Description : Self-checking bench for key_lut_mux_dflt with three          |
// |               parameterisations and a behavioural reference model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_key_lut_mux_dflt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ALU-internal table instance
  logic [5:0]  a_key;
  logic [3:0]  a_dflt;
  logic [59:0] a_lut;
  logic [3:0]  a_out, a_out_q;
  logic        a_hit, a_multi, a_hit_q;

  // Immediate-type table instance
  logic [4:0]  i_key_s;
  logic [2:0]  i_dflt;
  logic [39:0] i_lut;
  logic [2:0]  i_out, i_out_q;
  logic        i_hit, i_multi, i_hit_q;

  // Minimal instance
  logic [0:0]  e_key;
  logic [0:0]  e_dflt;
  logic [1:0]  e_lut;
  logic [0:0]  e_out, e_out_q;
  logic        e_hit, e_multi, e_hit_q;

  key_lut_mux_dflt #(.NR_KEY(6), .KEY_LEN(6), .DATA_LEN(4)) u_alu (
    .clk(clk), .rst(rst), .key(a_key), .default_out(a_dflt), .lut(a_lut),
    .out(a_out), .hit(a_hit), .multi_hit(a_multi), .out_q(a_out_q), .hit_q(a_hit_q));

  key_lut_mux_dflt #(.NR_KEY(5), .KEY_LEN(5), .DATA_LEN(3)) u_imm (
    .clk(clk), .rst(rst), .key(i_key_s), .default_out(i_dflt), .lut(i_lut),
    .out(i_out), .hit(i_hit), .multi_hit(i_multi), .out_q(i_out_q), .hit_q(i_hit_q));

  key_lut_mux_dflt #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_edge (
    .clk(clk), .rst(rst), .key(e_key), .default_out(e_dflt), .lut(e_lut),
    .out(e_out), .hit(e_hit), .multi_hit(e_multi), .out_q(e_out_q), .hit_q(e_hit_q));

  int n_checks = 0;
  int n_pass   = 0;

  int a_keys [8];
  int a_data [8];
  int m_keys [8];
  int m_data [8];

  int  exp_out;
  bit  exp_hit;
  bit  exp_multi;
  int  prev_out;
  bit  prev_hit;
  logic [63:0] packed_tbl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Table packed as {k0,d0,k1,d1,...}: shift earlier entries up as later ones are appended.
  function automatic logic [63:0] pack(input int nk, input int kl, input int dl,
                                       input int keys [8], input int datas [8]);
    logic [63:0] v = '0;
    for (int i = 0; i < nk; i++)
      v = (v << (kl + dl)) | (64'(keys[i]) << dl) | 64'(datas[i]);
    return v;
  endfunction

  // Reference: count matches, OR their data, fall back to default.
  function automatic void model(input int nk, input int keys [8], input int datas [8],
                                input int key, input int dflt,
                                output int o, output bit h, output bit m);
    int cnt = 0;
    int acc = 0;
    for (int i = 0; i < nk; i++)
      if (keys[i] == key) begin
        cnt++;
        acc = acc | datas[i];
      end
    o = (cnt == 0) ? dflt : acc;
    h = (cnt >= 1);
    m = (cnt >= 2);
  endfunction

  task automatic load_alu_default();
    for (int i = 0; i < 6; i++) begin
      a_keys[i] = 1 << (5 - i);
      a_data[i] = i;
    end
    packed_tbl = pack(6, 6, 4, a_keys, a_data);
    a_lut = packed_tbl[59:0];
  endtask

  initial begin
    a_dflt = 4'd15; a_key = 6'd0;
    i_dflt = 3'd1;  i_key_s = 5'd0;
    e_dflt = 1'b0;  e_key = 1'b0;
    load_alu_default();
    for (int i = 0; i < 5; i++) begin
      m_keys[i] = 1 << (4 - i);
      m_data[i] = i + 1;
    end
    packed_tbl = pack(5, 5, 3, m_keys, m_data);
    i_lut = packed_tbl[39:0];
    e_lut = 2'b01;

    // Reset state of the registered outputs
    #12;
    check("rst_out_q", 32'(a_out_q), 32'd0);
    check("rst_hit_q", 32'(a_hit_q), 32'd0);

    // Single hit and no match on the ALU table (combinational, works during reset)
    a_key = 6'b000100; #1;
    check("alu_single_out", 32'(a_out), 32'd3);
    check("alu_single_hit", 32'(a_hit), 32'd1);
    check("alu_single_multi", 32'(a_multi), 32'd0);
    a_key = 6'b000000; #1;
    check("alu_none_out", 32'(a_out), 32'd15);
    check("alu_none_hit", 32'(a_hit), 32'd0);
    check("alu_none_multi", 32'(a_multi), 32'd0);

    // Duplicate keys: data ORed, multi_hit raised
    a_keys[0] = 6'b101000; a_keys[2] = 6'b101000;
    packed_tbl = pack(6, 6, 4, a_keys, a_data); a_lut = packed_tbl[59:0];
    a_key = 6'b101000; #1;
    check("alu_dup_out", 32'(a_out), 32'd2);
    check("alu_dup_hit", 32'(a_hit), 32'd1);
    check("alu_dup_multi", 32'(a_multi), 32'd1);
    a_data[0] = 1;
    packed_tbl = pack(6, 6, 4, a_keys, a_data); a_lut = packed_tbl[59:0];
    #1;
    check("alu_dup_or_out", 32'(a_out), 32'd3);

    // Immediate-type table: directed points then full key sweep
    i_key_s = 5'b00010; #1;
    check("imm_hit_out", 32'(i_out), 32'd4);
    i_key_s = 5'b00000; #1;
    check("imm_none_out", 32'(i_out), 32'd1);
    check("imm_none_hit", 32'(i_hit), 32'd0);
    for (int k = 0; k < 32; k++) begin
      i_key_s = 5'(k); #1;
      model(5, m_keys, m_data, k, 1, exp_out, exp_hit, exp_multi);
      check($sformatf("imm_sweep_out_k%0d", k), 32'(i_out), 32'(exp_out));
      check($sformatf("imm_sweep_hit_k%0d", k), 32'(i_hit), 32'(exp_hit));
      check($sformatf("imm_sweep_multi_k%0d", k), 32'(i_multi), 32'(exp_multi));
    end

    // Edge parameters: single one-bit entry {0,1}, default 0
    e_key = 1'b0; #1;
    check("edge_k0_out", 32'(e_out), 32'd1);
    check("edge_k0_hit", 32'(e_hit), 32'd1);
    e_key = 1'b1; #1;
    check("edge_k1_out", 32'(e_out), 32'd0);
    check("edge_k1_hit", 32'(e_hit), 32'd0);

    // Registered path: release reset, load a value, then reset asynchronously mid-cycle
    load_alu_default();
    a_key = 6'b000100;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reg_load_out_q", 32'(a_out_q), 32'd3);
    check("reg_load_hit_q", 32'(a_hit_q), 32'd1);
    #2 rst = 1'b1; #1;
    check("async_rst_out_q", 32'(a_out_q), 32'd0);
    check("async_rst_hit_q", 32'(a_hit_q), 32'd0);
    check("async_rst_comb_out", 32'(a_out), 32'd3);
    @(negedge clk); rst = 1'b0;
    a_key = 6'b010000; #1;
    check("pre_edge_out_q", 32'(a_out_q), 32'd0);
    check("pre_edge_hit_q", 32'(a_hit_q), 32'd0);
    @(posedge clk); #1;
    check("post_edge_out_q", 32'(a_out_q), 32'd1);
    check("post_edge_hit_q", 32'(a_hit_q), 32'd1);
    a_key = 6'b000000; #1;
    check("hold_out_q", 32'(a_out_q), 32'd1);
    @(posedge clk); #1;
    check("miss_out_q", 32'(a_out_q), 32'd15);
    check("miss_hit_q", 32'(a_hit_q), 32'd0);

    // Randomized tables with a small key alphabet to provoke duplicates
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        a_keys[i] = int'($urandom_range(0, 7));
        a_data[i] = int'($urandom_range(0, 15));
      end
      packed_tbl = pack(6, 6, 4, a_keys, a_data); a_lut = packed_tbl[59:0];
      a_dflt = 4'($urandom_range(0, 15));
      a_key  = 6'($urandom_range(0, 9));
      #1;
      model(6, a_keys, a_data, int'(a_key), int'(a_dflt), exp_out, exp_hit, exp_multi);
      check($sformatf("rand_out_t%0d", t), 32'(a_out), 32'(exp_out));
      check($sformatf("rand_hit_t%0d", t), 32'(a_hit), 32'(exp_hit));
      check($sformatf("rand_multi_t%0d", t), 32'(a_multi), 32'(exp_multi));
      prev_out = exp_out;
      prev_hit = exp_hit;
      @(posedge clk); #1;
      check($sformatf("rand_out_q_t%0d", t), 32'(a_out_q), 32'(prev_out));
      check($sformatf("rand_hit_q_t%0d", t), 32'(a_hit_q), 32'(prev_hit));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_lut_mux_dflt.md
Name: key_lut_mux_dflt

Overview:
- Parameterised key-matching lookup multiplexer with a default value.
- Compares an input key against NR_KEY {key, data} pairs packed into one flat lookup-table bus.
- Outputs the data of the matching entry, or the default when nothing matches.
- Used throughout the control unit to turn one-hot decode vectors into ALU select, ALU-internal op and immediate-type codes. Also provides a registered copy of the result and hit flags for pipelined users.

Parameters:
- NR_KEY, 2: number of key/data pairs in the table (≥1).
- KEY_LEN, 1: width of each key in bits (≥1).
- DATA_LEN, 1: width of each data word and of the output in bits (≥1).

Ports:
- clk  in  1  clock for the registered outputs only.
- rst  in  1  asynchronous, active-high reset.
- key  in  KEY_LEN  lookup key.
- default_out  in  DATA_LEN  value driven when no entry matches.
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  packed table.
- out  out  DATA_LEN  combinational lookup result.
- hit  out  1  combinational: at least one entry matches.
- multi_hit  out  1  combinational: two or more entries match.
- out_q  out  DATA_LEN  out registered on the rising edge of clk.
- hit_q  out  1  hit registered on the rising edge of clk.

Behaviour:
- Table layout:
  - PAIR_LEN = KEY_LEN + DATA_LEN.
  - Entry i (i = 0..NR_KEY-1) occupies lut[(NR_KEY-i)*PAIR_LEN-1 -: PAIR_LEN], so entry 0 sits in the MSBs. This matches writing the table as {k0,d0,k1,d1,...}.
  - Within an entry, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
- Matching:
  - match[i] = (key == key_i), exact equality on all KEY_LEN bits.
  - There is no don't-care or X handling in keys.
- Output:
  - If no match[i] is set, out = default_out.
  - Otherwise out = bitwise OR of data_i over every i with match[i] set.
  - With a single match this is exactly that entry's data. With duplicate keys the results are ORed; there is no priority.
- Flags:
  - hit = OR of match.
  - multi_hit = 1 when the popcount of match is ≥ 2.
- Combinational paths:
  - out, hit and multi_hit are purely combinational from key, lut and default_out, with zero latency.
  - They are unaffected by clk and rst.
- Registered outputs:
  - out_q and hit_q update on every rising edge of clk with the current out and hit (one-cycle latency).
  - There is no enable.
- Reset:
  - While rst is high, out_q = 0 and hit_q = 0 immediately, independent of the clock.
  - The first capture happens at the first rising edge after rst deasserts.
  - Asserting rst mid-operation clears the registers without affecting the combinational outputs.
- Boundaries:
  - NR_KEY = 1 is legal.
  - A key of all zeros is a legal key and matches an entry whose key is all zeros.
  - A table entry whose key equals default_out has no special meaning.
- No state machine, no handshake.

Decomposition:
- Nothing goes into a shared package; the block is self-contained and parameterised.
- Control-unit code constants (ALU select codes 0–7, immediate-type codes 1–5, inside-op codes 0–5, default 15) belong in a shared control package, not in this block.
- Sub-module: a purely combinational core, key_lut_mux_core, computes out, hit and multi_hit. The top adds only the clk/rst register stage.

Test Plan:
- Single hit, ALU-internal table: NR_KEY=6, KEY_LEN=6, DATA_LEN=4, keys {100000, 010000, 001000, 000100, 000010, 000001} mapping to data 0..5, default 15.
  - key=6'b000100 -> out=3, hit=1, multi_hit=0.
- No match on the same table: key=6'b000000 -> out=15, hit=0, multi_hit=0.
- Multiple hits with overlapping data: set keys 0 and 2 to 6'b101000 (data 0 and 2), all other keys distinct.
  - key=6'b101000 -> out=2 (0|2), hit=1, multi_hit=1.
  - Swap data to 1 and 2 -> out=3.
- Immediate-type table: NR_KEY=5, KEY_LEN=5, DATA_LEN=3, default 1, keys 10000, 01000, 00100, 00010, 00001 mapping to 1..5.
  - key=5'b00010 -> out=4.
  - key=5'b00000 -> out=1, hit=0.
  - Sweep all 32 keys against a behavioural model.
- Registered path and reset:
  - Assert rst asynchronously mid-cycle -> out_q=0 and hit_q=0 at once.
  - Release rst, apply key=6'b010000 -> out_q=1 and hit_q=1 after the first rising edge, not before.
  - Change key to 6'b000000 -> out_q=15 and hit_q=0 one edge later.
- Edge parameters: NR_KEY=1, KEY_LEN=1, DATA_LEN=1 with table {0,1} and default 0.
  - key=0 -> out=1.
  - key=1 -> out=0.
